mod_74x191_n: RTL and testbench
===============================

// Module: mod_74x191_n
// PURPOSE
//   Parametrised cascade of 74x190/74x191-style synchronous up/down counters.
//   Counts in STAGES 4-bit digits, in binary (74x191) or BCD (74x190) mode.
//   Has synchronous parallel load, count enable, max/min detect and a
//   terminal-count output for cascading.
//   Replaces hand-chained single-chip counter instances in board-level models.
// PARAMETERS
//   STAGES  4  number of 4-bit digits; W = 4*STAGES; legal range 1..8
//   DECADE  0  0 = binary, each digit 0..15; 1 = BCD, each digit 0..9
// PORTS
//   CLK      in   1  clock; all state changes on rising edge
//   CLR_n    in   1  asynchronous active-low reset; clears Q to 0
//   LOAD_n   in   1  synchronous parallel load, active low
//   CTEN_n   in   1  count enable, active low
//   D_U      in   1  direction: 0 = up, 1 = down
//   D        in   W  parallel load data; digit k = D[4k+3:4k]
//   Q        out  W  counter state; digit k = Q[4k+3:4k]
//   MAX_MIN  out  1  terminal-count detect (combinational from Q and D_U)
//   RCO_n    out  1  ripple/terminal carry out, active low (combinational)
// BEHAVIOUR
//   Reset:
//   - CLR_n low clears Q to 0 immediately, without waiting for a clock edge.
//   - While CLR_n is low, LOAD_n and CTEN_n are ignored.
//   - Reset values: Q = 0, MAX_MIN = D_U, RCO_n = ~(D_U & ~CTEN_n).
//   - Deassertion takes effect at the next rising edge.
//   - Clearing mid-count abandons the count; no partial state remains.
//   Priority at each rising edge (CLR_n high):
//   - LOAD_n low: Q <= D.
//   - else CTEN_n low: count by one in direction D_U.
//   - else: hold.
//   - Load latency is 1 cycle. There is no async load; load overrides count.
//   Count rules, applied per digit with an internal carry chain:
//   - Digit 0 always steps when counting.
//   - Digit k steps only if digits 0..k-1 are all at their terminal value
//     (up: 15 in binary / 9 in BCD; down: 0).
//   - Binary up: 15 -> 0 with carry. Binary down: 0 -> 15 with borrow.
//   - BCD up: 9 -> 0 with carry. BCD down: 0 -> 9 with borrow.
//   - Whole-counter wrap: up from all-terminal gives 0.
//     Down from 0 gives all-15 (binary) or all-9 (BCD).
//   Invalid BCD digits (10..15, reachable only via load, DECADE=1):
//   - Up: the digit goes to 0. It is not a terminal value, so no carry.
//   - Down: the digit decrements (e.g. 12 -> 11). No borrow.
//   - Invalid digits never satisfy the terminal test, so MAX_MIN stays 0.
//   MAX_MIN:
//   - High when D_U=0 and every digit is terminal-up (all F / all 9).
//   - High when D_U=1 and Q == 0.
//   - Changes the same cycle as D_U changes (combinational).
//   RCO_n:
//   - RCO_n = ~(MAX_MIN & ~CTEN_n); a one-cycle low pulse at the wrap count.
//   - Cascade: drive the next device's CTEN_n from this RCO_n.
//   Simultaneous events:
//   - Direction change while counting takes effect on the same edge.
//   - LOAD_n with CTEN_n low: load wins and Q = D exactly.
// TESTING
//   1. Async clear: Q=0x1234, pull CLR_n low mid-cycle -> Q=0 before the
//      next edge. Hold CLR_n low with LOAD_n low 3 clks -> Q stays 0.
//   2. Binary up wrap, STAGES=2: load 0xFE, count up 2 clks -> Q=0xFF with
//      MAX_MIN=1 and RCO_n=0, then Q=0x00 with RCO_n=1.
//   3. Binary down wrap, STAGES=2: load 0x01, D_U=1, count 2 clks -> 0x00
//      with MAX_MIN=1, then 0xFF. Setting CTEN_n=1 at Q=0 makes RCO_n=1.
//   4. BCD, STAGES=2: load 0x98, up 3 clks -> 0x99, 0x00, 0x01.
//      Load 0x10, down 1 clk -> 0x09.
//   5. Invalid BCD, DECADE=1: load 0x0C, up 1 clk -> 0x00 (no carry).
//      Load 0x0C, down 1 clk -> 0x0B. MAX_MIN=0 throughout.
//   6. Priority: LOAD_n=0, CTEN_n=0, D=0x0005 -> Q=0x0005 after 1 clk.
//      LOAD_n=1, CTEN_n=1 for 4 clks -> Q holds 0x0005.

Source files
------------

// File: rtl/mod_74x191_n.sv
// Cascade of 74x190/74x191-style up/down counters: STAGES 4-bit digits,
// binary or BCD, with synchronous load, count enable and terminal-count outputs.
module mod_74x191_n #(
    parameter int STAGES = 4,
    parameter bit DECADE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  CLR_n,
    input  logic                  LOAD_n,
    input  logic                  CTEN_n,
    input  logic                  D_U,
    input  logic [4*STAGES-1:0]   D,
    output logic [4*STAGES-1:0]   Q,
    output logic                  MAX_MIN,
    output logic                  RCO_n
);

    localparam int         W   = 4 * STAGES;
    localparam logic [3:0] TOP = DECADE ? 4'd9 : 4'd15;

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;
    logic         w_all_term;

    // Invalid BCD digits (10..15) fold to 0 going up and simply decrement going down.
    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic down);
        if (!down) begin
            if (DECADE && (d >= 4'd9)) return 4'd0;
            return d + 4'd1;
        end
        if (DECADE && (d == 4'd0)) return 4'd9;
        return d - 4'd1;
    endfunction

    // A digit steps only while every lower digit sits at its terminal value.
    always_comb begin : p_next
        logic       v_carry;
        logic [3:0] v_dig;
        w_next     = r_q;
        v_carry    = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            v_dig = r_q[4*k +: 4];
            if (v_carry) begin
                w_next[4*k +: 4] = step_digit(v_dig, D_U);
            end
            v_carry = v_carry & (D_U ? (v_dig == 4'd0) : (v_dig == TOP));
        end
        w_all_term = v_carry;
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_q <= '0;
        end else if (!LOAD_n) begin
            r_q <= D;
        end else if (!CTEN_n) begin
            r_q <= w_next;
        end
    end

    assign Q       = r_q;
    assign MAX_MIN = w_all_term;
    assign RCO_n   = ~(w_all_term & ~CTEN_n);

endmodule

// File: tb/tb_mod_74x191_n.sv
// Randomized and directed bench for mod_74x191_n: two binary cascades
// (2 and 3 digits) and one 2-digit BCD cascade checked against integer models.
module tb_mod_74x191_n;

    logic        clk;
    logic        clr_n;
    logic        load_n;
    logic        cten_n;
    logic        d_u;
    logic [7:0]  d2;
    logic [11:0] d3;
    logic [7:0]  dbcd;
    logic [7:0]  q2;
    logic [11:0] q3;
    logic [7:0]  qb;
    logic        mm2, mm3, mmb;
    logic        rco2, rco3, rcob;

    int n_cmp;
    int n_err;
    int m2, m3, mb;
    bit bcd_ok;

    mod_74x191_n #(.STAGES(2), .DECADE(1'b0)) u_bin2 (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .CTEN_n(cten_n), .D_U(d_u),
        .D(d2), .Q(q2), .MAX_MIN(mm2), .RCO_n(rco2)
    );

    mod_74x191_n #(.STAGES(3), .DECADE(1'b0)) u_bin3 (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .CTEN_n(cten_n), .D_U(d_u),
        .D(d3), .Q(q3), .MAX_MIN(mm3), .RCO_n(rco3)
    );

    mod_74x191_n #(.STAGES(2), .DECADE(1'b1)) u_bcd2 (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .CTEN_n(cten_n), .D_U(d_u),
        .D(dbcd), .Q(qb), .MAX_MIN(mmb), .RCO_n(rcob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int from_bcd(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    task automatic check_all();
        bit e2, e3, eb;
        e2 = d_u ? (m2 == 0) : (m2 == 255);
        e3 = d_u ? (m3 == 0) : (m3 == 4095);
        eb = d_u ? (mb == 0) : (mb == 99);
        chk("bin2_q",   32'(q2),   32'(m2));
        chk("bin2_mm",  32'(mm2),  32'(e2));
        chk("bin2_rco", 32'(rco2), 32'(!(e2 && !cten_n)));
        chk("bin3_q",   32'(q3),   32'(m3));
        chk("bin3_mm",  32'(mm3),  32'(e3));
        chk("bin3_rco", 32'(rco3), 32'(!(e3 && !cten_n)));
        if (bcd_ok) begin
            chk("bcd_q",   32'(qb),   32'(to_bcd(mb)));
            chk("bcd_mm",  32'(mmb),  32'(eb));
            chk("bcd_rco", 32'(rcob), 32'(!(eb && !cten_n)));
        end
    endtask

    // Advance the models by the rules for the inputs now applied, then clock.
    task automatic tick();
        if (!clr_n) begin
            m2 = 0; m3 = 0; mb = 0;
        end else if (!load_n) begin
            m2 = int'(d2); m3 = int'(d3); mb = from_bcd(dbcd);
        end else if (!cten_n) begin
            if (d_u) begin
                m2 = (m2 + 255) % 256; m3 = (m3 + 4095) % 4096; mb = (mb + 99) % 100;
            end else begin
                m2 = (m2 + 1) % 256;   m3 = (m3 + 1) % 4096;    mb = (mb + 1) % 100;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic load(input logic [7:0] v2, input logic [11:0] v3, input logic [7:0] vb);
        load_n = 1'b0; d2 = v2; d3 = v3; dbcd = vb;
        tick();
        load_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; bcd_ok = 1'b1;
        m2 = 0; m3 = 0; mb = 0;
        clr_n = 1'b1; load_n = 1'b1; cten_n = 1'b1; d_u = 1'b0;
        d2 = '0; d3 = '0; dbcd = '0;
        #2 clr_n = 1'b0;
        #1 check_all();
        @(posedge clk); #1;
        d_u = 1'b1; cten_n = 1'b0;
        #1 check_all();
        d_u = 1'b0; cten_n = 1'b1;
        #1 clr_n = 1'b1;

        // Async clear mid-cycle, then clear dominating load.
        load(8'h34, 12'h234, 8'h34);
        #2 clr_n = 1'b0; m2 = 0; m3 = 0; mb = 0;
        #1 check_all();
        load_n = 1'b0; d2 = 8'h77; d3 = 12'h777; dbcd = 8'h77;
        repeat (3) tick();
        load_n = 1'b1; clr_n = 1'b1;

        // Up wrap (binary and BCD).
        load(8'hFE, 12'hFFE, 8'h98);
        cten_n = 1'b0; d_u = 1'b0;
        repeat (3) tick();
        cten_n = 1'b1;

        // Down wrap, then RCO released by CTEN_n at zero.
        d_u = 1'b1;
        load(8'h01, 12'h001, 8'h01);
        cten_n = 1'b0;
        repeat (2) tick();
        cten_n = 1'b1;
        load(8'h01, 12'h001, 8'h01);
        cten_n = 1'b0;
        tick();
        cten_n = 1'b1;
        #1 check_all();

        // Borrow across a digit.
        load(8'h10, 12'h100, 8'h10);
        cten_n = 1'b0;
        tick();
        cten_n = 1'b1;

        // Invalid BCD digits.
        bcd_ok = 1'b0;
        d_u = 1'b0;
        load(8'h0C, 12'h00C, 8'h0C);
        chk("bcd_inv_mm_ld", 32'(mmb), 32'd0);
        cten_n = 1'b0;
        tick();
        chk("bcd_inv_up", 32'(qb), 32'h00);
        chk("bcd_inv_mm_up", 32'(mmb), 32'd0);
        cten_n = 1'b1;
        d_u = 1'b1;
        load(8'h0C, 12'h00C, 8'h0C);
        cten_n = 1'b0;
        tick();
        chk("bcd_inv_dn", 32'(qb), 32'h0B);
        chk("bcd_inv_mm_dn", 32'(mmb), 32'd0);
        cten_n = 1'b1;

        // Load beats count, then hold.
        bcd_ok = 1'b1;
        load_n = 1'b0; cten_n = 1'b0; d2 = 8'h05; d3 = 12'h005; dbcd = 8'h05;
        tick();
        chk("prio_load", 32'(qb), 32'h05);
        load_n = 1'b1; cten_n = 1'b1;
        repeat (4) tick();

        // Randomized traffic, including direction flips and occasional clears.
        for (int i = 0; i < 400; i++) begin
            clr_n  = ($urandom_range(0, 99) >= 3);
            load_n = ($urandom_range(0, 99) >= 10);
            cten_n = ($urandom_range(0, 99) >= 75);
            d_u    = ($urandom_range(0, 99) >= 50);
            d2     = 8'($urandom);
            d3     = ($urandom_range(0, 1) == 1) ? 12'hFFF - 12'($urandom_range(0, 3)) : 12'($urandom);
            dbcd   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (!clr_n) begin
                m2 = 0; m3 = 0; mb = 0;
            end
            #1 check_all();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
